uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
UART transmit sequencer placed between the TX FIFO and the serial line. It pops one word at a time from the TX FIFO through the FIFO's wr_en/rd_en-style read port. It serializes each word as a start bit, DATA_SIZE data bits (LSB first) and 1 or 2 stop bits, at a programmable baud divisor. It is the read-side client of the FIFO; the register bank drives tx_en, div and nstop.

Parameters:
DATA_SIZE, 8, width of one FIFO word and number of data bits per frame
DIV_WIDTH, 16, width of baud divisor

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
tx_en  input  1  transmit enable from register bank
nstop  input  1  0: one stop bit, 1: two stop bits
div  input  DIV_WIDTH  baud divisor; bit period = div+1 clock cycles
fifo_empty  input  1  TX FIFO empty flag
fifo_rd_data  input  DATA_SIZE  TX FIFO read data; valid the cycle after the rd_en pulse (read pointer advances on that edge)
fifo_rd_en  output  1  one-cycle FIFO pop strobe
txd  output  1  serial line, idle high
busy  output  1  high whenever state != IDLE
tx_done  output  1  one-cycle pulse at end of each frame

Behaviour:
- Reset (reset=0, asynchronous) forces the following immediately, without waiting for a clock edge:
  - state IDLE; txd=1, fifo_rd_en=0, busy=0, tx_done=0.
  - baud counter, bit counter and shift register all 0.
- States: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE: if tx_en=1 and fifo_empty=0 at a rising edge, go to POP; otherwise stay.
- POP: fifo_rd_en=1 for exactly this one cycle; next state LOAD. fifo_rd_en is 0 in every other state.
- LOAD: on exit, capture fifo_rd_data into the shift register and sample div and nstop into internal registers. Clear the baud counter; next state START.
- START: txd=0 for div_reg+1 cycles; then go to DATA with bit counter 0.
- DATA: txd=shift[0]. Each bit lasts div_reg+1 cycles. At the end of a bit, shift right and increment the bit counter. After DATA_SIZE bits, go to STOP.
- STOP: txd=1 for (nstop_reg+1)*(div_reg+1) cycles. On the last cycle, tx_done=1 for that single cycle. Next state:
  - POP if tx_en=1 and fifo_empty=0 (back-to-back frames);
  - else IDLE.
- txd is 1 in IDLE, POP and LOAD.
- txd and fifo_rd_en are decoded from registers only; there is no combinational path from inputs.
- Latency: tx_en & !fifo_empty sampled at edge k → fifo_rd_en high during cycle k..k+1, txd falls one cycle after LOAD.
- Frame length: (1 + DATA_SIZE + 1 + nstop)*(div+1) cycles from txd falling to the end of STOP.
- Back-to-back gap: exactly 2 idle-high cycles (POP, LOAD) between consecutive frames.
- Mid-frame changes:
  - div or nstop changes take effect only at the next LOAD.
  - tx_en deassertion lets the current frame finish; no further pop occurs.
- fifo_empty is ignored outside IDLE and the STOP exit decision, so the block never pops an empty FIFO.
- Reset mid-frame abandons the frame: txd returns to 1 at once and no pop is issued. The word already popped is lost.
- Counter rules:
  - The baud counter counts 0..div_reg and wraps.
  - div=0 gives one cycle per bit.
  - div=2^DIV_WIDTH-1 must work without overflow; the counter is DIV_WIDTH bits wide.

Test Plan:
- Reset and idle: hold reset=0, then release with fifo_empty=1, tx_en=1 → txd=1, busy=0, fifo_rd_en=0, tx_done=0 for 100 cycles.
- Single frame: FIFO holds 0xA5, div=3, nstop=0, tx_en=1 → one fifo_rd_en pulse. txd then carries 0 (4 cycles), bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 (4 cycles), for a 40-cycle frame. tx_done pulses once on the final stop cycle; busy drops the next cycle.
- Back-to-back: FIFO holds 0x00 then 0xFF, div=0, nstop=1 → two 11-cycle frames separated by exactly 2 txd=1 cycles. Exactly two rd_en pulses, then the block returns to IDLE.
- Config change mid-frame: start 0x3C with div=1, change div to 5 during DATA → the frame keeps 2-cycle bits. The next frame uses 6-cycle bits.
- tx_en drop: FIFO holds 2 words, deassert tx_en during the first frame's DATA → the first frame completes intact, no second pop, txd=1, busy=0.
- Async reset mid-frame: assert reset=0 between clock edges during DATA → txd=1 and busy=0 before the next edge. After release with tx_en=1, the next FIFO word is popped and sent normally.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops one word from the TX FIFO and serializes it as
// start bit, DATA_SIZE data bits LSB first, and 1 or 2 stop bits at div+1 clocks per bit.
module uart_tx_ctrl #(
    parameter int DATA_SIZE = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tx_en,
    input  logic                 nstop,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 fifo_empty,
    input  logic [DATA_SIZE-1:0] fifo_rd_data,
    output logic                 fifo_rd_en,
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int BW = $clog2(DATA_SIZE + 1);

    typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;

    state_t               state, state_nxt;
    logic [DIV_WIDTH-1:0] baud_cnt, div_reg;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_SIZE-1:0] shift;
    logic                 nstop_reg, stop_cnt;
    logic                 bit_end, last_data, last_stop;

    assign bit_end   = (baud_cnt == div_reg);
    assign last_data = (bit_cnt == BW'(DATA_SIZE - 1));
    assign last_stop = (stop_cnt == nstop_reg);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Outputs decode state and counters only; inputs steer transitions alone.
    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        txd        = 1'b1;
        busy       = 1'b1;
        tx_done    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (tx_en && !fifo_empty) state_nxt = POP;
            end
            POP: begin
                fifo_rd_en = 1'b1;
                state_nxt  = LOAD;
            end
            LOAD: state_nxt = START;
            START: begin
                txd = 1'b0;
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                txd = shift[0];
                if (bit_end && last_data) state_nxt = STOP;
            end
            STOP: begin
                if (bit_end && last_stop) begin
                    tx_done   = 1'b1;
                    state_nxt = (tx_en && !fifo_empty) ? POP : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            div_reg   <= '0;
            nstop_reg <= 1'b0;
            stop_cnt  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    shift     <= fifo_rd_data;
                    div_reg   <= div;
                    nstop_reg <= nstop;
                    baud_cnt  <= '0;
                    bit_cnt   <= '0;
                    stop_cnt  <= 1'b0;
                end
                START, DATA, STOP: begin
                    baud_cnt <= bit_end ? '0 : baud_cnt + DIV_WIDTH'(1);
                    if (bit_end && state == DATA) begin
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                    // Second stop bit only runs when nstop_reg is set.
                    if (bit_end && state == STOP) stop_cnt <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: FIFO model plus a timeline-based frame
// reference model, directed scenarios and a randomized run.
module tb_uart_tx_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        tx_en = 1'b0;
    logic        nstop = 1'b0;
    logic [15:0] div   = '0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_rd_data = '0;
    logic        fifo_rd_en, txd, busy, tx_done;

    uart_tx_ctrl #(.DATA_SIZE(8), .DIV_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .tx_en(tx_en), .nstop(nstop), .div(div),
        .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en(fifo_rd_en), .txd(txd), .busy(busy), .tx_done(tx_done)
    );

    always #5 clock = ~clock;

    int         n_cmp = 0;
    int         n_err = 0;
    int         n_pops = 0;
    int         n_dones = 0;
    logic [7:0] fq[$];

    // Model: m_t = cycles since the pop strobe (-1 when idle).
    int         m_t = -1;
    int         m_div = 0;
    int         m_ns = 0;
    logic [7:0] m_word = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int flen();
        return (10 + m_ns) * (m_div + 1);
    endfunction

    task automatic check_outputs();
        logic e_txd, e_busy, e_rd, e_done;
        int   k, b;
        e_txd  = 1'b1;
        e_busy = (m_t >= 0);
        e_rd   = (m_t == 0);
        e_done = 1'b0;
        if (m_t >= 2) begin
            k = m_t - 2;
            b = k / (m_div + 1);
            if (b == 0)      e_txd = 1'b0;
            else if (b <= 8) e_txd = m_word[b-1];
            e_done = (k == flen() - 1);
        end
        chk("txd", txd, e_txd);
        chk("busy", busy, e_busy);
        chk("rd_en", fifo_rd_en, e_rd);
        chk("tx_done", tx_done, e_done);
    endtask

    task automatic push(input logic [7:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock: advance the model using the inputs present at the coming edge,
    // service the FIFO after the edge, compare outputs at the falling edge.
    task automatic cyc();
        logic popped;
        popped = fifo_rd_en;
        if (m_t >= 0) begin
            if (m_t == 1) begin
                m_div  = int'(div);
                m_ns   = int'(nstop);
                m_word = fifo_rd_data;
            end
            if (m_t >= 2 && (m_t - 2) == flen() - 1)
                m_t = (tx_en && !fifo_empty) ? 0 : -1;
            else
                m_t++;
        end else if (tx_en && !fifo_empty) begin
            m_t = 0;
        end
        @(posedge clock);
        #1;
        if (popped) begin
            chk("pop_nonempty", fq.size() != 0, 1);
            if (fq.size() != 0) fifo_rd_data = fq.pop_front();
            fifo_empty = (fq.size() == 0);
        end
        @(negedge clock);
        check_outputs();
        if (fifo_rd_en) n_pops++;
        if (tx_done)    n_dones++;
    endtask

    task automatic run_to_data(input string tag);
        int ok = 0;
        for (int n = 0; n < 400 && ok == 0; n++) begin
            cyc();
            if (m_t >= 2 && (m_t - 2) / (m_div + 1) >= 2 && (m_t - 2) / (m_div + 1) <= 8) ok = 1;
        end
        chk(tag, ok, 1);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic mid_reset();
        #2 reset = 1'b0;
        #1;
        chk("arst_txd", txd, 1);
        chk("arst_busy", busy, 0);
        chk("arst_rd_en", fifo_rd_en, 0);
        chk("arst_done", tx_done, 0);
        m_t = -1;
        repeat (2) begin
            @(posedge clock);
            #1;
            chk("arst_hold_txd", txd, 1);
            chk("arst_hold_busy", busy, 0);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int p0, d0;
        tx_en = 1'b1;
        div   = 16'd3;
        #1;
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_done", tx_done, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Idle with empty FIFO
        repeat (100) cyc();

        // Single 0xA5 frame, div=3, one stop bit
        p0 = n_pops; d0 = n_dones;
        div = 16'd3; nstop = 1'b0;
        push(8'hA5);
        repeat (50) cyc();
        chk("a5_pops", n_pops - p0, 1);
        chk("a5_dones", n_dones - d0, 1);

        // Back-to-back 0x00, 0xFF, div=0, two stop bits
        p0 = n_pops; d0 = n_dones;
        div = 16'd0; nstop = 1'b1;
        push(8'h00); push(8'hFF);
        repeat (40) cyc();
        chk("b2b_pops", n_pops - p0, 2);
        chk("b2b_dones", n_dones - d0, 2);

        // div change during DATA only affects the next frame
        div = 16'd1; nstop = 1'b0;
        push(8'h3C); push(8'h5A);
        run_to_data("cfg_reach_data");
        div = 16'd5;
        repeat (120) cyc();
        chk("cfg_fifo_drained", fq.size(), 0);

        // tx_en drop during DATA: frame completes, no further pop
        div = 16'd2;
        push(8'h11); push(8'h22);
        run_to_data("txen_reach_data");
        tx_en = 1'b0;
        repeat (60) cyc();
        chk("txen_left_in_fifo", fq.size(), 1);

        // Async reset mid-frame; popped word lost, next word sent normally
        push(8'h33);
        tx_en = 1'b1;
        run_to_data("arst_reach_data");
        mid_reset();
        p0 = n_pops;
        repeat (60) cyc();
        chk("arst_repop", n_pops - p0, 1);
        chk("arst_fifo_drained", fq.size(), 0);

        // Maximum divisor: start bit must hold for the whole window
        div = 16'hFFFF; nstop = 1'b0;
        push(8'h7E);
        repeat (300) cyc();
        mid_reset();

        // Randomized traffic and config changes
        div = 16'd1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0 && fq.size() < 4) push(8'($urandom));
            if ($urandom_range(0, 19) == 0) div = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) nstop = 1'($urandom);
            if ($urandom_range(0, 49) == 0) tx_en = ~tx_en;
            cyc();
        end
        tx_en = 1'b1;
        repeat (300) cyc();
        chk("rand_fifo_drained", fq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
